// File: rtl/common_pkg.sv
// Shared ALU control encodings used by the ALU and its arbiter wrapper.
package common;

  typedef logic [2:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 3'b000;
  localparam alu_ctrl_t ALU_SUB = 3'b001;

endpackage

// File: rtl/alu.sv
// Two-operation ALU: add / subtract modulo 2^WIDTH, anything else yields 0.
module alu
  import common::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] alu_result,
  output logic             z
);

  // Select the operation; unsupported codes collapse to zero so Z reads 1.
  always_comb begin
    alu_result = '0;
    case (alu_control)
      ALU_ADD: alu_result = a + b;
      ALU_SUB: alu_result = a - b;
      default: alu_result = '0;
    endcase
  end

  assign z = (alu_result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first asserted request at or after ptr_i,
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);

  logic        found;
  int unsigned j;

  // Walk the requesters starting at the pointer and take the first one.
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (en_i && !found && req_i[j]) begin
        found       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters through a round-robin grant and a
// single-entry, flow-through response slot tagged with the requester id.
module alu_arbiter
  import common::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*3-1:0]     req_ctrl,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     rsp_zero
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q,  rsp_zero_d;
  logic [ID_W-1:0]  ptr_q,       ptr_d;

  logic             can_issue;
  logic             arb_en;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             transfer;
  logic [WIDTH-1:0] a_sel, b_sel, alu_res;
  logic [2:0]       ctrl_sel;
  logic             alu_z;

  // The slot can be refilled in the same cycle it drains.
  assign can_issue = !rsp_valid_q || rsp_ready;
  assign arb_en    = can_issue && !reset;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_rr (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .en_i        (arb_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & grant);

  assign a_sel    = req_a[grant_idx*WIDTH +: WIDTH];
  assign b_sel    = req_b[grant_idx*WIDTH +: WIDTH];
  assign ctrl_sel = req_ctrl[grant_idx*3 +: 3];

  alu #(.WIDTH(WIDTH)) u_alu (
    .a           (a_sel),
    .b           (b_sel),
    .alu_control (ctrl_sel),
    .alu_result  (alu_res),
    .z           (alu_z)
  );

  // Next state of the response slot and the round-robin pointer.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    ptr_d        = ptr_q;
    if (transfer) begin
      rsp_valid_d  = 1'b1;
      rsp_id_d     = grant_idx;
      rsp_result_d = alu_res;
      rsp_zero_d   = alu_z;
      ptr_d        = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; pointer 0 gives requester 0 priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      ptr_q        <= '0;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      ptr_q        <= ptr_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a table of per-cycle inputs with expected
// grant and visible response, then a hand-written stall/overflow sequence.
module tb_alu_arbiter;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [2*W-1:0] req_a, req_b;
  logic [5:0]    req_ctrl;
  logic          rsp_valid, rsp_ready;
  logic          rsp_id;
  logic [W-1:0]  rsp_result;
  logic          rsp_zero;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(W), .NUM_REQ(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ctrl   (req_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
  );

  typedef struct {
    logic         rst;
    logic [1:0]   vld;
    logic [W-1:0] a0, b0, a1, b1;
    logic [2:0]   c0, c1;
    logic         rr;
    logic [1:0]   exp_rdy;
    logic         chk;
    logic         exp_v;
    logic         exp_id;
    logic [W-1:0] exp_res;
    logic         exp_z;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic rst, logic [1:0] vld,
                              logic [W-1:0] a0, logic [W-1:0] b0, logic [2:0] c0,
                              logic [W-1:0] a1, logic [W-1:0] b1, logic [2:0] c1,
                              logic rr, logic [1:0] exp_rdy, logic chk,
                              logic exp_v, logic exp_id, logic [W-1:0] exp_res,
                              logic exp_z);
    vec_t v;
    v.rst = rst; v.vld = vld; v.a0 = a0; v.b0 = b0; v.c0 = c0;
    v.a1 = a1; v.b1 = b1; v.c1 = c1; v.rr = rr; v.exp_rdy = exp_rdy;
    v.chk = chk; v.exp_v = exp_v; v.exp_id = exp_id; v.exp_res = exp_res;
    v.exp_z = exp_z;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic rst, logic [1:0] vld, logic [W-1:0] a0, logic [W-1:0] b0,
                       logic [2:0] c0, logic [W-1:0] a1, logic [W-1:0] b1,
                       logic [2:0] c1, logic rr);
    reset     = rst;
    req_valid = vld;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    req_ctrl  = {c1, c0};
    rsp_ready = rr;
  endtask

  task automatic check_rsp(string tag, logic v, logic id, logic [W-1:0] res, logic z);
    check({tag, ".rsp_valid"},  64'(rsp_valid),  64'(v));
    check({tag, ".rsp_id"},     64'(rsp_id),     64'(id));
    check({tag, ".rsp_result"}, 64'(rsp_result), 64'(res));
    check({tag, ".rsp_zero"},   64'(rsp_zero),   64'(z));
  endtask

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] ILL = 3'b111;

  initial begin
    drive(1'b1, 2'b11, 0, 0, ADD, 0, 0, ADD, 1'b1);

    // rst vld   a0 b0 c0   a1  b1 c1   rr rdy    chk v  id res            z
    tbl[0]  = mk(1, 2'b11, 5, 7, ADD, 9, 9, SUB, 1, 2'b00, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 2'b11, 5, 7, ADD, 9, 9, SUB, 1, 2'b00, 1, 0, 0, 0, 0);
    tbl[2]  = mk(0, 2'b11, 5, 7, ADD, 9, 9, SUB, 1, 2'b01, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 2'b10, 5, 7, ADD, 9, 9, SUB, 1, 2'b10, 1, 1, 0, 12, 0);
    tbl[4]  = mk(0, 2'b10, 5, 7, ADD, 3, 5, SUB, 1, 2'b10, 1, 1, 1, 0, 1);
    tbl[5]  = mk(0, 2'b00, 5, 7, ADD, 3, 5, SUB, 1, 2'b00, 1, 1, 1, 32'hFFFF_FFFE, 0);
    tbl[6]  = mk(0, 2'b00, 1, 2, ADD, 10, 4, SUB, 1, 2'b00, 1, 0, 1, 32'hFFFF_FFFE, 0);
    tbl[7]  = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b01, 1, 0, 1, 32'hFFFF_FFFE, 0);
    tbl[8]  = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b10, 1, 1, 0, 3, 0);
    tbl[9]  = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b01, 1, 1, 1, 6, 0);
    tbl[10] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b10, 1, 1, 0, 3, 0);
    tbl[11] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b01, 1, 1, 1, 6, 0);
    tbl[12] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b10, 1, 1, 0, 3, 0);
    tbl[13] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 0, 2'b00, 1, 1, 1, 6, 0);
    tbl[14] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 0, 2'b00, 1, 1, 1, 6, 0);
    tbl[15] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 0, 2'b00, 1, 1, 1, 6, 0);
    tbl[16] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b01, 1, 1, 1, 6, 0);
    tbl[17] = mk(0, 2'b00, 1, 2, ADD, 10, 4, SUB, 1, 2'b00, 1, 1, 0, 3, 0);
    tbl[18] = mk(0, 2'b01, 1, 1, ILL, 10, 4, SUB, 1, 2'b01, 1, 0, 0, 3, 0);
    tbl[19] = mk(0, 2'b00, 1, 1, ILL, 10, 4, SUB, 0, 2'b00, 1, 1, 0, 0, 1);
    tbl[20] = mk(1, 2'b11, 1, 2, ADD, 10, 4, SUB, 0, 2'b00, 1, 1, 0, 0, 1);
    tbl[21] = mk(0, 2'b11, 1, 2, ADD, 10, 4, SUB, 1, 2'b01, 1, 0, 0, 0, 0);
    tbl[22] = mk(0, 2'b00, 1, 2, ADD, 10, 4, SUB, 0, 2'b00, 1, 1, 0, 3, 0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].vld, tbl[i].a0, tbl[i].b0, tbl[i].c0,
            tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].rr);
      #1;
      check($sformatf("row%0d.req_ready", i), 64'(req_ready), 64'(tbl[i].exp_rdy));
      if (tbl[i].chk)
        check_rsp($sformatf("row%0d", i), tbl[i].exp_v, tbl[i].exp_id,
                  tbl[i].exp_res, tbl[i].exp_z);
    end

    // Stall with req1 waiting on an overflowing add; the pending response
    // from req0 must stay put and no grant may appear.
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      drive(1'b0, 2'b10, 0, 0, ADD, 32'hFFFF_FFFF, 1, ADD, 1'b0);
      #1;
      check($sformatf("stall%0d.req_ready", s), 64'(req_ready), 64'(2'b00));
      check_rsp($sformatf("stall%0d", s), 1'b1, 1'b0, 32'd3, 1'b0);
    end
    // Drain and refill together: pointer sits at 1 after the last req0 grant.
    @(negedge clk);
    drive(1'b0, 2'b10, 0, 0, ADD, 32'hFFFF_FFFF, 1, ADD, 1'b1);
    #1;
    check("drain.req_ready", 64'(req_ready), 64'(2'b10));
    check_rsp("drain", 1'b1, 1'b0, 32'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 2'b01, 0, 1, SUB, 0, 0, ADD, 1'b1);
    #1;
    check("wrap.req_ready", 64'(req_ready), 64'(2'b01));
    check_rsp("wrap", 1'b1, 1'b1, 32'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 2'b00, 0, 0, ADD, 0, 0, ADD, 1'b1);
    #1;
    check_rsp("underflow", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    #1;
    check_rsp("idle", 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
